// File: rtl/iter_shift_unit.sv
// Iterative shifter/rotator: moves up to STEP bit positions per clock, with valid/ready on both sides.
// Results are registered on entry to DONE, so data_out/carry_out/err stay put outside DONE.
module iter_shift_unit #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shift,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [2:0] M_SLL = 3'd0;
  localparam logic [2:0] M_SRL = 3'd1;
  localparam logic [2:0] M_SRA = 3'd2;
  localparam logic [2:0] M_ROL = 3'd3;
  localparam logic [2:0] M_ROR = 3'd4;
  localparam logic [SHW-1:0] STEP_C = SHW'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [2:0]       mode_q, mode_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic             sign_q, sign_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic [SHW-1:0]   sh_sat;
  logic [SHW-1:0]   step_n;
  logic [WIDTH-1:0] step_w;
  logic             step_c;
  logic             reserved_in;

  // Amounts >= WIDTH are only expressible when WIDTH is not a power of two.
  if ((1 << SHW) == WIDTH) begin : g_sat_none
    assign sh_sat = shift;
  end else begin : g_sat_clip
    assign sh_sat = (shift > SHW'(WIDTH - 1)) ? SHW'(WIDTH - 1) : shift;
  end

  assign reserved_in = (mode >= 3'd5);
  assign step_n      = (rem_q > STEP_C) ? STEP_C : rem_q;

  // One clock's worth of work: step_n single-bit moves, carry follows the last bit out.
  always_comb begin
    step_w = work_q;
    step_c = carry_q;
    for (int i = 0; i < STEP; i++) begin
      if (SHW'(i) < step_n) begin
        case (mode_q)
          M_SLL: begin
            step_c = step_w[WIDTH-1];
            step_w = {step_w[WIDTH-2:0], 1'b0};
          end
          M_SRL: begin
            step_c = step_w[0];
            step_w = {1'b0, step_w[WIDTH-1:1]};
          end
          M_SRA: begin
            step_c = step_w[0];
            step_w = {sign_q, step_w[WIDTH-1:1]};
          end
          M_ROL: begin
            step_c = step_w[WIDTH-1];
            step_w = {step_w[WIDTH-2:0], step_w[WIDTH-1]};
          end
          M_ROR: begin
            step_c = step_w[0];
            step_w = {step_w[0], step_w[WIDTH-1:1]};
          end
          default: begin
            step_c = carry_q;
            step_w = work_q;
          end
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    sign_d  = sign_q;
    carry_d = carry_q;
    res_d   = res_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          work_d  = data_in;
          mode_d  = mode;
          rem_d   = reserved_in ? '0 : sh_sat;
          sign_d  = data_in[WIDTH-1];
          carry_d = 1'b0;
          // Zero-count and reserved requests still take one SHIFT pass so they surface one edge later.
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        work_d  = step_w;
        carry_d = step_c;
        rem_d   = rem_q - step_n;
        if (rem_q == step_n) begin
          state_d = S_DONE;
          res_d   = step_w;
          cout_d  = step_c;
          err_d   = (mode_q >= 3'd5);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      mode_q  <= '0;
      rem_q   <= '0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      sign_q  <= sign_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign data_out  = res_q;
  assign carry_out = cout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit: directed cases on an 8-bit/STEP=1 instance, random sweep on 16-bit/STEP=3.
// Expected results are queued at issue time and retired by per-instance monitors.
module tb_iter_shift_unit;

  typedef struct packed {
    logic [15:0] d;
    logic        c;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8 = 1'b1, iv8 = 1'b0, or8 = 1'b1;
  logic       ir8, ov8, c8, e8;
  logic [7:0] d8i = '0, d8o;
  logic [2:0] sh8 = '0, m8 = '0;

  logic        rst16 = 1'b1, iv16 = 1'b0, or16 = 1'b1;
  logic        ir16, ov16, c16, e16;
  logic [15:0] d16i = '0, d16o;
  logic [3:0]  sh16 = '0;
  logic [2:0]  m16 = '0;

  logic rnd16 = 1'b0;
  int   total = 0;
  int   bad   = 0;
  exp_t q8[$];
  exp_t q16[$];

  iter_shift_unit #(.WIDTH(8), .STEP(1)) u8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .data_in(d8i), .shift(sh8),
    .mode(m8), .out_valid(ov8), .out_ready(or8), .data_out(d8o), .carry_out(c8), .err(e8)
  );

  iter_shift_unit #(.WIDTH(16), .STEP(3)) u16 (
    .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16), .data_in(d16i), .shift(sh16),
    .mode(m16), .out_valid(ov16), .out_ready(or16), .data_out(d16o), .carry_out(c16), .err(e16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: whole-word arithmetic on the original operand.
  function automatic exp_t ref_op(input int w, input logic [15:0] d, input int s, input logic [2:0] m);
    logic [31:0] mask, x, r;
    exp_t e;
    mask = (32'd1 << w) - 32'd1;
    x    = {16'b0, d} & mask;
    e    = '0;
    r    = x;
    if (m >= 3'd5) begin
      e.d = x[15:0];
      e.e = 1'b1;
    end else if (s == 0) begin
      e.d = x[15:0];
    end else begin
      case (m)
        3'd0: begin r = (x << s) & mask; e.c = x[w-s]; end
        3'd1: begin r = x >> s; e.c = x[s-1]; end
        3'd2: begin r = (x >> s) | (x[w-1] ? (mask & ~(mask >> s)) : 32'd0); e.c = x[s-1]; end
        3'd3: begin r = ((x << s) | (x >> (w - s))) & mask; e.c = r[0]; end
        default: begin r = ((x >> s) | (x << (w - s))) & mask; e.c = r[w-1]; end
      endcase
      e.d = r[15:0];
    end
    return e;
  endfunction

  function automatic int lat_of(input int s, input logic [2:0] m, input int step);
    if (m >= 3'd5 || s == 0) return 1;
    return (s + step - 1) / step;
  endfunction

  function automatic logic rdy(input int u);
    return (u == 0) ? ir8 : ir16;
  endfunction

  function automatic logic vld(input int u);
    return (u == 0) ? ov8 : ov16;
  endfunction

  // Issue one request on instance u; lat < 0 skips the latency check.
  task automatic drive(input int u, input logic [15:0] d, input int s, input logic [2:0] m,
                       input exp_t ex, input int lat, input logic push);
    int g;
    g = 0;
    while (rdy(u) !== 1'b1 && g < 200) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 200) begin
      chk("in_ready_timeout", 32'(rdy(u)), 32'd1);
      return;
    end
    if (u == 0) begin
      if (push) q8.push_back(ex);
      iv8 = 1'b1; d8i = d[7:0]; sh8 = s[2:0]; m8 = m;
      @(posedge clk); #1; iv8 = 1'b0;
    end else begin
      if (push) q16.push_back(ex);
      iv16 = 1'b1; d16i = d; sh16 = s[3:0]; m16 = m;
      @(posedge clk); #1; iv16 = 1'b0;
    end
    if (lat >= 0) begin
      g = 0;
      while (vld(u) !== 1'b1 && g < 100) begin
        @(posedge clk); #1; g++;
      end
      chk((u == 0) ? "latency8" : "latency16", g, lat);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst8 && ov8 && or8) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL out8_unexpected: got data %0h with nothing outstanding", d8o);
      end else begin
        e = q8.pop_front();
        chk("data8", 32'(d8o), 32'(e.d[7:0]));
        chk("carry8", 32'(c8), 32'(e.c));
        chk("err8", 32'(e8), 32'(e.e));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst16 && ov16 && or16) begin
      if (q16.size() == 0) begin
        total++; bad++;
        $display("FAIL out16_unexpected: got data %0h with nothing outstanding", d16o);
      end else begin
        e = q16.pop_front();
        chk("data16", 32'(d16o), 32'(e.d));
        chk("carry16", 32'(c16), 32'(e.c));
        chk("err16", 32'(e16), 32'(e.e));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd16) or16 = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [7:0] held_d;
    logic       held_c;
    int         s, g;
    logic [2:0] m;
    logic [15:0] d;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready8", 32'(ir8), 32'd0);
    chk("rst_out_valid8", 32'(ov8), 32'd0);
    chk("rst_data8", 32'(d8o), 32'd0);
    chk("rst_carry8", 32'(c8), 32'd0);
    chk("rst_err8", 32'(e8), 32'd0);
    chk("rst_in_ready16", 32'(ir16), 32'd0);
    rst8 = 1'b0; rst16 = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready8", 32'(ir8), 32'd1);

    drive(0, 16'h003C, 3, 3'd0, '{16'h00E0, 1'b1, 1'b0}, 3, 1'b1);
    drive(0, 16'h00B1, 2, 3'd1, '{16'h002C, 1'b0, 1'b0}, 2, 1'b1);
    drive(0, 16'h00D0, 2, 3'd2, '{16'h00F4, 1'b0, 1'b0}, 2, 1'b1);
    drive(0, 16'h0081, 1, 3'd3, '{16'h0003, 1'b1, 1'b0}, 1, 1'b1);
    drive(0, 16'h008F, 0, 3'd2, '{16'h008F, 1'b0, 1'b0}, 1, 1'b1);
    drive(0, 16'h005A, 4, 3'd6, '{16'h005A, 1'b0, 1'b1}, 1, 1'b1);

    // Backpressure: ROR result must sit still while the consumer stalls.
    @(posedge clk); #1;
    or8 = 1'b0;
    drive(0, 16'h008F, 3, 3'd4, '{16'h00F1, 1'b1, 1'b0}, 3, 1'b1);
    held_d = d8o;
    held_c = c8;
    for (int i = 0; i < 5; i++) begin
      iv8 = ~i[0]; d8i = 8'($urandom); sh8 = 3'd1; m8 = 3'd0;
      @(posedge clk); #1;
      chk("bp_valid", 32'(ov8), 32'd1);
      chk("bp_data", 32'(d8o), 32'(held_d));
      chk("bp_carry", 32'(c8), 32'(held_c));
      chk("bp_in_ready", 32'(ir8), 32'd0);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(ov8), 32'd0);
    chk("bp_release_in_ready", 32'(ir8), 32'd1);

    // Reset lands on the second SHIFT edge; that operand must never appear.
    drive(0, 16'h00FF, 7, 3'd0, '0, -1, 1'b0);
    @(posedge clk); #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(ov8), 32'd0);
    chk("midrst_data", 32'(d8o), 32'd0);
    chk("midrst_in_ready", 32'(ir8), 32'd0);
    rst8 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_stale", 32'(q8.size()), 32'd0);
    drive(0, 16'h0080, 7, 3'd1, '{16'h0001, 1'b0, 1'b0}, 7, 1'b1);

    for (int i = 0; i < 60; i++) begin
      d = 16'($urandom_range(0, 255));
      s = $urandom_range(0, 7);
      m = 3'($urandom_range(0, 7));
      drive(0, d, s, m, ref_op(8, d, s, m), lat_of(s, m, 1), 1'b1);
    end

    drive(1, 16'h0001, 15, 3'd0, '{16'h8000, 1'b0, 1'b0}, 5, 1'b1);
    rnd16 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      d = 16'($urandom);
      s = $urandom_range(0, 15);
      m = 3'($urandom_range(0, 7));
      drive(1, d, s, m, ref_op(16, d, s, m), lat_of(s, m, 3), 1'b1);
    end

    g = 0;
    while ((q8.size() != 0 || q16.size() != 0) && g < 500) begin
      @(posedge clk); #1; g++;
    end
    chk("drain", 32'(q8.size() + q16.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
